// File: rtl/except_ctrl_pkg.sv
// Shared exception codes, MEM-stage flag bit positions, CP0 register
// addresses and the resolver FSM state type.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_TR   = 32'h0000_000D;
  localparam logic [31:0] EXC_ADEL = 32'h0000_000E;
  localparam logic [31:0] EXC_ADES = 32'h0000_000F;
  localparam logic [31:0] EXC_ERET = 32'h0000_0010;

  localparam int unsigned FLAG_SYSCALL = 0;
  localparam int unsigned FLAG_BREAK   = 1;
  localparam int unsigned FLAG_RI      = 2;
  localparam int unsigned FLAG_OV      = 3;
  localparam int unsigned FLAG_TRAP    = 4;
  localparam int unsigned FLAG_ERET    = 5;
  localparam int unsigned FLAG_IF_ADEL = 6;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } exc_state_e;

endpackage

// File: rtl/except_ctrl_int_sync.sv
// Two-flop synchroniser for the raw asynchronous hardware interrupt lines.
module int_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception resolver: prioritises exceptions/interrupts against
// WB-forwarded CP0 state and sequences the pipeline flush / redirect PC.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_exc_flags_i,
  input  logic        mem_load_adel_i,
  input  logic        mem_store_ades_i,
  input  logic [31:0] mem_mem_addr_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_inst_addr_o,
  output logic        exc_in_delayslot_o,
  output logic [31:0] bad_vaddr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic [31:0] status_fwd, cause_fwd, epc_fwd;
  logic        int_pending;
  logic [31:0] code;
  logic [31:0] bad_vaddr;
  logic        unused_ok;

  int_sync #(.WIDTH(6)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_i),
    .q   (int_sync_o)
  );

  // Only the software-interrupt bits of Cause are writable via mtc0.
  always_comb begin
    status_fwd = cp0_status_i;
    cause_fwd  = cp0_cause_i;
    epc_fwd    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_STATUS) status_fwd = wb_cp0_data_i;
      if (wb_cp0_waddr_i == CP0_EPC)    epc_fwd    = wb_cp0_data_i;
      if (wb_cp0_waddr_i == CP0_CAUSE)  cause_fwd[9:8] = wb_cp0_data_i[9:8];
    end
  end

  assign int_pending = ((cause_fwd[15:8] & status_fwd[15:8]) != 8'h00) &&
                       status_fwd[0] && !status_fwd[1];

  always_comb begin
    code      = '0;
    bad_vaddr = '0;
    if (!rst && state_q == ST_IDLE && mem_valid_i) begin
      if (int_pending) begin
        code = EXC_INT;
      end else if (mem_exc_flags_i[FLAG_IF_ADEL]) begin
        code      = EXC_ADEL;
        bad_vaddr = mem_inst_addr_i;
      end else if (mem_exc_flags_i[FLAG_RI]) begin
        code = EXC_RI;
      end else if (mem_exc_flags_i[FLAG_SYSCALL]) begin
        code = EXC_SYS;
      end else if (mem_exc_flags_i[FLAG_BREAK]) begin
        code = EXC_BP;
      end else if (mem_exc_flags_i[FLAG_OV]) begin
        code = EXC_OV;
      end else if (mem_exc_flags_i[FLAG_TRAP]) begin
        code = EXC_TR;
      end else if (mem_load_adel_i) begin
        code      = EXC_ADEL;
        bad_vaddr = mem_mem_addr_i;
      end else if (mem_store_ades_i) begin
        code      = EXC_ADES;
        bad_vaddr = mem_mem_addr_i;
      end else if (mem_exc_flags_i[FLAG_ERET]) begin
        code = EXC_ERET;
      end
    end
  end

  assign excepttype_o       = code;
  assign bad_vaddr_o        = bad_vaddr;
  assign exc_inst_addr_o    = rst ? '0 : mem_inst_addr_i;
  assign exc_in_delayslot_o = rst ? 1'b0 : mem_in_delayslot_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    new_pc_d = new_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (code != '0) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          cnt_d    = CNT_INIT;
          new_pc_d = (code == EXC_ERET) ? epc_fwd : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          flush_d  = 1'b0;
          new_pc_d = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign flush_o  = flush_q;
  assign new_pc_o = new_pc_q;

  assign unused_ok = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16],
                       cause_fwd[7:0], mem_exc_flags_i[7]};

endmodule

// File: tb/tb_except_ctrl.sv
// Randomised self-checking bench for except_ctrl against a behavioural
// priority-table / flush-countdown reference model.
module tb_except_ctrl;

  localparam logic [31:0] VEC   = 32'hBFC0_0380;
  localparam int          NFLSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        mem_valid_i;
  logic [7:0]  mem_exc_flags_i;
  logic        mem_load_adel_i, mem_store_ades_i;
  logic [31:0] mem_mem_addr_i, mem_inst_addr_i;
  logic        mem_in_delayslot_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [5:0]  int_sync_o;
  logic [31:0] excepttype_o, exc_inst_addr_o, bad_vaddr_o, new_pc_o;
  logic        exc_in_delayslot_o, flush_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: flush cycles still to show, expected redirect PC,
  // and history of int_i values seen at each rising edge.
  int          m_left = 0;
  logic [31:0] m_pc   = '0;
  logic [5:0]  ihist[$];

  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(NFLSH)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .mem_valid_i(mem_valid_i),
    .mem_exc_flags_i(mem_exc_flags_i), .mem_load_adel_i(mem_load_adel_i),
    .mem_store_ades_i(mem_store_ades_i), .mem_mem_addr_i(mem_mem_addr_i),
    .mem_inst_addr_i(mem_inst_addr_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i), .int_sync_o(int_sync_o),
    .excepttype_o(excepttype_o), .exc_inst_addr_o(exc_inst_addr_o),
    .exc_in_delayslot_o(exc_in_delayslot_o), .bad_vaddr_o(bad_vaddr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_comb(output logic [31:0] code, output logic [31:0] bv,
                                     output logic [31:0] epc);
    logic [31:0] st, ca;
    logic [9:0]  hit;
    logic [31:0] codes [10];
    bit          found;
    codes = '{32'h01, 32'h0E, 32'h0A, 32'h08, 32'h09, 32'h0C, 32'h0D, 32'h0E, 32'h0F, 32'h10};
    st  = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
    epc = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
    ca  = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
    hit[0] = (((ca & st) >> 8) & 32'hFF) != 0 && st[0] == 1'b1 && st[1] == 1'b0;
    hit[1] = mem_exc_flags_i[6];
    hit[2] = mem_exc_flags_i[2];
    hit[3] = mem_exc_flags_i[0];
    hit[4] = mem_exc_flags_i[1];
    hit[5] = mem_exc_flags_i[3];
    hit[6] = mem_exc_flags_i[4];
    hit[7] = mem_load_adel_i;
    hit[8] = mem_store_ades_i;
    hit[9] = mem_exc_flags_i[5];
    code  = 0;
    bv    = 0;
    found = 0;
    if (!rst && m_left == 0 && mem_valid_i) begin
      for (int i = 0; i < 10; i++) begin
        if (!found && hit[i]) begin
          found = 1;
          code  = codes[i];
          if (i == 1) bv = mem_inst_addr_i;
          if (i == 7 || i == 8) bv = mem_mem_addr_i;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_left = 0;
    m_pc   = '0;
    ihist.delete();
  endtask

  // Called just after an input change (posedge+1); returns just after the next posedge.
  task automatic step();
    logic [31:0] ec, bv, epc;
    logic [5:0]  isync;
    #3;
    model_comb(ec, bv, epc);
    chk("excepttype", excepttype_o, ec);
    chk("bad_vaddr", bad_vaddr_o, bv);
    chk("exc_pc", exc_inst_addr_o, rst ? 32'h0 : mem_inst_addr_i);
    chk("dslot", {31'b0, exc_in_delayslot_o}, {31'b0, rst ? 1'b0 : mem_in_delayslot_i});
    @(posedge clk);
    if (!rst) begin
      ihist.push_back(int_i);
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) m_pc = '0;
      end else if (ec != 0) begin
        m_left = NFLSH;
        m_pc   = (ec == 32'h10) ? epc : VEC;
      end
    end
    #1;
    isync = (ihist.size() >= 2) ? ihist[ihist.size()-2] : 6'h00;
    chk("flush", {31'b0, flush_o}, {31'b0, m_left != 0});
    chk("new_pc", new_pc_o, m_pc);
    chk("int_sync", {26'b0, int_sync_o}, {26'b0, isync});
  endtask

  task automatic clear_exc();
    mem_exc_flags_i  = '0;
    mem_load_adel_i  = 1'b0;
    mem_store_ades_i = 1'b0;
    wb_cp0_we_i      = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    clear_exc();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; int_i = 6'h3F; mem_valid_i = 1'b1; clear_exc();
    mem_exc_flags_i = 8'h01; mem_mem_addr_i = '0; mem_inst_addr_i = 32'h1234;
    mem_in_delayslot_i = 1'b1; cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
    wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
    step(); step();
    chk("rst_exc", excepttype_o, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);

    // Release reset with interrupts held high; synchronised copy appears on edge 2.
    rst = 1'b0; clear_exc(); mem_in_delayslot_i = 1'b0;
    step();
    chk("sync_edge1", {26'b0, int_sync_o}, 32'h00);
    step();
    chk("sync_edge2", {26'b0, int_sync_o}, 32'h3F);
    int_i = 6'h00;
    idle_steps(2);

    // Syscall at 0xBFC00100.
    mem_inst_addr_i = 32'hBFC0_0100; mem_exc_flags_i = 8'h01;
    #3;
    chk("sys_code", excepttype_o, 32'h08);
    chk("sys_pc", exc_inst_addr_o, 32'hBFC0_0100);
    step();
    chk("sys_flush1", {31'b0, flush_o}, 32'h1);
    chk("sys_newpc", new_pc_o, VEC);
    mem_exc_flags_i = 8'h02;   // break arriving during FLUSH is ignored
    #3;
    chk("flush_ignore", excepttype_o, 32'h0);
    step();
    chk("sys_flush2", {31'b0, flush_o}, 32'h1);
    clear_exc();
    step();
    chk("sys_flush_end", {31'b0, flush_o}, 32'h0);
    idle_steps(1);

    // Eret with EPC forwarded from WB mtc0.
    cp0_epc_i = 32'h1000; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14;
    wb_cp0_data_i = 32'h2000; mem_exc_flags_i = 8'h20;
    #3;
    chk("eret_code", excepttype_o, 32'h10);
    step();
    chk("eret_pc", new_pc_o, 32'h2000);
    idle_steps(3);

    // Load ADEL together with overflow: overflow wins, no bad address.
    mem_mem_addr_i = 32'h3; mem_load_adel_i = 1'b1; mem_exc_flags_i = 8'h08;
    #3;
    chk("ov_code", excepttype_o, 32'h0C);
    chk("ov_bad", bad_vaddr_o, 32'h0);
    step();
    idle_steps(3);
    mem_load_adel_i = 1'b1;
    #3;
    chk("adel_code", excepttype_o, 32'h0E);
    chk("adel_bad", bad_vaddr_o, 32'h3);
    step();
    idle_steps(3);

    // Interrupt vs syscall; then Status mtc0 clearing IE suppresses it.
    cp0_status_i = 32'h0000_FF01; int_i = 6'h01; mem_valid_i = 1'b0;
    idle_steps(2);
    chk("int_sync0", {26'b0, int_sync_o}, 32'h01);
    mem_valid_i = 1'b1; cp0_cause_i = 32'h0000_0400; mem_exc_flags_i = 8'h01;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_FF00;
    #3;
    chk("int_masked", excepttype_o, 32'h08);
    wb_cp0_we_i = 1'b0;
    #1;
    chk("int_wins", excepttype_o, 32'h01);
    step();
    idle_steps(3);
    mem_valid_i = 1'b0;
    #1;
    chk("bubble_no_int", excepttype_o, 32'h0);
    cp0_cause_i = '0; int_i = '0; mem_valid_i = 1'b1;
    idle_steps(3);

    // Reset asserted mid-FLUSH drops flush_o at once.
    mem_exc_flags_i = 8'h04;
    step();
    clear_exc();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_mid_pc", new_pc_o, 32'h0);
    model_reset();
    #2 rst = 1'b0;
    idle_steps(3);

    for (int n = 0; n < 600; n++) begin
      mem_valid_i        = ($urandom_range(0, 4) != 0);
      mem_exc_flags_i    = '0;
      if ($urandom_range(0, 2) == 0) mem_exc_flags_i[$urandom_range(0, 6)] = 1'b1;
      if ($urandom_range(0, 5) == 0) mem_exc_flags_i[$urandom_range(0, 6)] = 1'b1;
      mem_exc_flags_i[7] = 1'(($urandom() & 32'h1));
      mem_load_adel_i    = ($urandom_range(0, 7) == 0);
      mem_store_ades_i   = ($urandom_range(0, 7) == 0);
      mem_mem_addr_i     = $urandom();
      mem_inst_addr_i    = $urandom();
      mem_in_delayslot_i = 1'(($urandom() & 32'h1));
      cp0_status_i       = ($urandom() & 32'h0000_FF03) | 32'h1;
      if ($urandom_range(0, 3) == 0) cp0_status_i[1] = 1'b1;
      cp0_cause_i        = ($urandom_range(0, 5) == 0) ? $urandom() : ($urandom() & 32'hFFFF_00FF);
      cp0_epc_i          = $urandom();
      wb_cp0_we_i        = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: wb_cp0_waddr_i = 5'd12;
        1: wb_cp0_waddr_i = 5'd13;
        2: wb_cp0_waddr_i = 5'd14;
        default: wb_cp0_waddr_i = 5'd5;
      endcase
      wb_cp0_data_i      = $urandom();
      if ($urandom_range(0, 3) == 0) int_i = 6'($urandom());
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
